tick_repeater: RTL and testbench

- Clocked, tick-accurate redstone repeater stage. It sits directly downstream of comparator_sub and consumes its 4-bit front strength.
- Applies a selectable 1..MAX_DELAY redstone-tick delay, pulse extension and side locking.
- Re-drives the output at full strength (15) for the next dust/comparator stage.
- Replaces the untimed, buf-delay repeater model with synthesizable game-tick behaviour.

---
 rtl/tick_repeater.sv | 112 +++++++++++
 tb/tb_tick_repeater.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_repeater.sv
// Tick-accurate redstone repeater: 1..MAX_DELAY rt delay, pulse extension, optional side lock.
// Ports: clk, reset_n, tick_en, in_ss, lock_ss, delay_sel -> out_ss, out_on, busy, rtick. Macro: REPEATER_LOCK_EN.
module tick_repeater #(
  parameter int MAX_DELAY = 4,
  parameter int GT_PER_RT = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       tick_en,
  input  logic [3:0]                 in_ss,
  input  logic [3:0]                 lock_ss,
  input  logic [((MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1)-1:0] delay_sel,
  output logic [3:0]                 out_ss,
  output logic                       out_on,
  output logic                       busy,
  output logic                       rtick
);

  localparam int DW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int PW = (GT_PER_RT > 1) ? $clog2(GT_PER_RT) : 1;
  localparam logic [PW-1:0] PSC_TOP = PW'(GT_PER_RT - 1);
  localparam logic [DW-1:0] DMAX    = DW'(MAX_DELAY - 1);
  localparam logic [DW:0]   MAX_V   = (DW + 1)'(MAX_DELAY);

  typedef enum logic [1:0] {
    OFF,
    PEND_ON,
    ON,
    PEND_OFF
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [PW-1:0] psc;
  logic          rt_evt;
  logic          in_on;
  logic          locked;
  logic [DW-1:0] dsel;

  assign rt_evt = tick_en && (psc == PSC_TOP);
  assign in_on  = |in_ss;

  // Out-of-range selects only exist for non-power-of-two MAX_DELAY.
  assign dsel = ({1'b0, delay_sel} >= MAX_V) ? DMAX : delay_sel;

`ifdef REPEATER_LOCK_EN
  assign locked = |lock_ss;
`else
  logic lock_unused;
  assign lock_unused = ^lock_ss;
  assign locked      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= OFF;
      cnt    <= '0;
      psc    <= '0;
      out_ss <= 4'd0;
      out_on <= 1'b0;
      busy   <= 1'b0;
      rtick  <= 1'b0;
    end else begin
      rtick <= rt_evt;
      if (tick_en)
        psc <= rt_evt ? '0 : psc + 1'b1;
      // A lock freezes state and cnt; the prescaler keeps counting.
      if (rt_evt && !locked) begin
        unique case (state)
          OFF: begin
            if (in_on) begin
              state <= PEND_ON;
              cnt   <= dsel;
              busy  <= 1'b1;
            end
          end
          PEND_ON: begin
            if (cnt == '0) begin
              state  <= ON;
              busy   <= 1'b0;
              out_on <= 1'b1;
              out_ss <= 4'd15;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ON: begin
            if (!in_on) begin
              state <= PEND_OFF;
              cnt   <= dsel;
              busy  <= 1'b1;
            end
          end
          PEND_OFF: begin
            if (cnt == '0) begin
              state  <= OFF;
              busy   <= 1'b0;
              out_on <= 1'b0;
              out_ss <= 4'd0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= OFF;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tick_repeater.sv
// Self-checking bench for tick_repeater (MAX_DELAY=4, GT_PER_RT=2).
// Table of per-rt-event vectors plus hand sequences for reset and prescaler.
module tb_tick_repeater;

  logic       clk;
  logic       reset_n;
  logic       tick_en;
  logic [3:0] in_ss;
  logic [3:0] lock_ss;
  logic [1:0] delay_sel;
  logic [3:0] out_ss;
  logic       out_on;
  logic       busy;
  logic       rtick;

  int total = 0;
  int bad   = 0;

  tick_repeater #(
    .MAX_DELAY(4),
    .GT_PER_RT(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tick_en  (tick_en),
    .in_ss    (in_ss),
    .lock_ss  (lock_ss),
    .delay_sel(delay_sel),
    .out_ss   (out_ss),
    .out_on   (out_on),
    .busy     (busy),
    .rtick    (rtick)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0] in_ss;
    logic [3:0] lock_ss;
    logic [1:0] dsel;
    logic [3:0] exp_ss;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; drives tick_en for one cycle, returns at next negedge.
  task automatic tick(input logic te);
    tick_en = te;
    @(posedge clk);
    @(negedge clk);
    tick_en = 1'b0;
  endtask

  // Two consecutive game ticks: the second is the rt event.
  task automatic rt();
    tick(1'b1);
    tick(1'b1);
  endtask

  task automatic add(input logic [3:0] i, input logic [3:0] l,
                     input logic [1:0] d, input logic [3:0] s,
                     input logic b);
    vec_t v;
    v.in_ss    = i;
    v.lock_ss  = l;
    v.dsel     = d;
    v.exp_ss   = s;
    v.exp_busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    // Basic delay, D=4: rise after ev4, fall after ev14.
    add(7, 0, 3, 0, 1);
    add(7, 0, 3, 0, 1);
    add(7, 0, 3, 0, 1);
    add(7, 0, 3, 0, 1);
    add(7, 0, 3, 15, 0);
    for (int i = 5; i < 10; i++) add(7, 0, 3, 15, 0);
    add(0, 0, 3, 15, 1);
    add(0, 0, 3, 15, 1);
    add(0, 0, 3, 15, 1);
    add(0, 0, 3, 15, 1);
    add(0, 0, 3, 0, 0);
    // Pulse extension, D=3, 1-rt input pulse.
    add(1, 0, 2, 0, 1);
    add(0, 0, 2, 0, 1);
    add(0, 0, 2, 0, 1);
    add(0, 0, 2, 15, 0);
    add(0, 0, 2, 15, 1);
    add(0, 0, 2, 15, 1);
    add(0, 0, 2, 15, 1);
    add(0, 0, 2, 0, 0);
    // delay_sel change mid-pending: rise still at +4, fall uses D=1.
    add(5, 0, 3, 0, 1);
    add(5, 0, 0, 0, 1);
    add(5, 0, 0, 0, 1);
    add(5, 0, 0, 0, 1);
    add(5, 0, 0, 15, 0);
    add(0, 0, 0, 15, 1);
    add(0, 0, 0, 0, 0);
    // Lock, D=2: reach ON, drop input while locked for 6 rt.
    add(3, 0, 1, 0, 1);
    add(3, 0, 1, 0, 1);
    add(3, 0, 1, 15, 0);
`ifdef REPEATER_LOCK_EN
    for (int i = 0; i < 6; i++) add(0, 5, 1, 15, 0);
    add(0, 0, 1, 15, 1);
    add(0, 0, 1, 15, 1);
    add(0, 0, 1, 0, 0);
`else
    add(0, 5, 1, 15, 1);
    add(0, 5, 1, 15, 1);
    for (int i = 0; i < 4; i++) add(0, 5, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 0);
`endif
    // Reach ON with D=4, then enter PEND_OFF.
    add(3, 0, 3, 0, 1);
    add(3, 0, 3, 0, 1);
    add(3, 0, 3, 0, 1);
    add(3, 0, 3, 0, 1);
    add(3, 0, 3, 15, 0);
    add(0, 0, 3, 15, 1);
    add(0, 0, 3, 15, 1);

    reset_n   = 1'b0;
    tick_en   = 1'b0;
    in_ss     = 4'd9;
    lock_ss   = 4'd0;
    delay_sel = 2'd0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick(i[0]);
    chk("rst out_ss", int'(out_ss), 0);
    chk("rst out_on", int'(out_on), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst rtick", int'(rtick), 0);

    in_ss   = 4'd0;
    reset_n = 1'b1;
    tick(1'b1);
    chk("pre tick1 rtick", int'(rtick), 0);
    tick(1'b0);
    chk("pre idle rtick", int'(rtick), 0);
    tick(1'b1);
    chk("pre tick2 rtick", int'(rtick), 1);
    tick(1'b0);
    chk("pre after rtick", int'(rtick), 0);
    chk("pre out_ss", int'(out_ss), 0);

    foreach (vecs[k]) begin
      in_ss     = vecs[k].in_ss;
      lock_ss   = vecs[k].lock_ss;
      delay_sel = vecs[k].dsel;
      rt();
      chk($sformatf("v%0d out_ss", k), int'(out_ss), int'(vecs[k].exp_ss));
      chk($sformatf("v%0d out_on", k), int'(out_on),
          int'(vecs[k].exp_ss != 4'd0));
      chk($sformatf("v%0d busy", k), int'(busy), int'(vecs[k].exp_busy));
      chk($sformatf("v%0d rtick", k), int'(rtick), 1);
    end

    // Async reset mid-cycle while in PEND_OFF.
    in_ss   = 4'd0;
    lock_ss = 4'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst out_ss", int'(out_ss), 0);
    chk("arst out_on", int'(out_on), 0);
    chk("arst busy", int'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rt();
      chk($sformatf("post%0d out_ss", i), int'(out_ss), 0);
      chk($sformatf("post%0d busy", i), int'(busy), 0);
      chk($sformatf("post%0d rtick", i), int'(rtick), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
